// File: rtl/capture_run_sequencer_if.sv
// Control/status bundle between the capture run sequencer and the start logic,
// datapath, result-RAM write port and transfer unit.
interface capture_run_sequencer_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int RUN_WIDTH  = 8
);
  logic                  start;
  logic [RUN_WIDTH-1:0]  num_runs;
  logic                  abort;
  logic                  xfer_done;
  logic                  dut_reset;
  logic                  dut_enable;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  xfer_req;
  logic                  busy;
  logic                  done;
  logic [RUN_WIDTH-1:0]  run_index;

  // master: the sequencer itself
  modport master (
    input  start, num_runs, abort, xfer_done,
    output dut_reset, dut_enable, ram_we, ram_addr, xfer_req, busy, done, run_index
  );

  // slave: the surrounding start logic / datapath / transfer unit
  modport slave (
    output start, num_runs, abort, xfer_done,
    input  dut_reset, dut_enable, ram_we, ram_addr, xfer_req, busy, done, run_index
  );
endinterface

// File: rtl/capture_run_sequencer.sv
// Batched capture-run scheduler: flush, refill, capture RAM_DEPTH results,
// then hand the RAM to the transfer unit; repeated for each run of a batch.
module capture_run_sequencer #(
  parameter int ADDR_WIDTH   = 14,
  parameter int RAM_DEPTH    = 16384,
  parameter int PIPE_LATENCY = 8,
  parameter int FLUSH_CYCLES = 4,
  parameter int RUN_WIDTH    = 8
) (
  input  logic                    variable_clk_2,
  input  logic                    reset,
  capture_run_sequencer_if.master seq_io
);

  localparam int MAX_FP = (FLUSH_CYCLES > PIPE_LATENCY) ? FLUSH_CYCLES : PIPE_LATENCY;
  localparam int MAX_C  = (MAX_FP > RAM_DEPTH) ? MAX_FP : RAM_DEPTH;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_FILL,
    S_CAPTURE,
    S_XFER
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [RUN_WIDTH-1:0]  runs_q;
  logic [RUN_WIDTH-1:0]  run_idx_q;
  logic                  done_flag_q;

  logic                  dut_reset_q;
  logic                  dut_enable_q;
  logic                  ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  xfer_req_q;
  logic                  busy_q;
  logic                  done_q;
  logic [RUN_WIDTH-1:0]  run_index_q;

  always_ff @(posedge variable_clk_2) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      runs_q       <= '0;
      run_idx_q    <= '0;
      done_flag_q  <= 1'b0;
      dut_reset_q  <= 1'b0;
      dut_enable_q <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      xfer_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      run_index_q  <= '0;
    end else begin
      // Outputs are a registered decode of the current state, so they trail it by one edge.
      dut_reset_q  <= (state_q == S_FLUSH);
      dut_enable_q <= (state_q == S_FILL) || (state_q == S_CAPTURE);
      ram_we_q     <= (state_q == S_CAPTURE);
      xfer_req_q   <= (state_q == S_XFER);
      busy_q       <= (state_q != S_IDLE);
      done_q       <= done_flag_q;
      run_index_q  <= run_idx_q;
      if (state_q == S_CAPTURE)
        ram_addr_q <= ADDR_WIDTH'(cnt_q);
      else if (state_q == S_XFER)
        ram_addr_q <= ADDR_WIDTH'(RAM_DEPTH - 1);
      else
        ram_addr_q <= '0;

      if (state_q == S_IDLE) begin
        cnt_q <= '0;
        if (seq_io.start) begin
          runs_q      <= (seq_io.num_runs == '0) ? RUN_WIDTH'(1) : seq_io.num_runs;
          run_idx_q   <= '0;
          done_flag_q <= 1'b0;
          state_q     <= S_FLUSH;
        end
      end else if (seq_io.abort) begin
        cnt_q   <= '0;
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_FLUSH: begin
            if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
              cnt_q   <= '0;
              state_q <= (PIPE_LATENCY == 0) ? S_CAPTURE : S_FILL;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_FILL: begin
            if (cnt_q == CNT_W'(PIPE_LATENCY - 1)) begin
              cnt_q   <= '0;
              state_q <= S_CAPTURE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_CAPTURE: begin
            if (cnt_q == CNT_W'(RAM_DEPTH - 1)) begin
              cnt_q   <= '0;
              state_q <= S_XFER;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_XFER: begin
            cnt_q <= '0;
            if (seq_io.xfer_done) begin
              if (run_idx_q + RUN_WIDTH'(1) < runs_q) begin
                run_idx_q <= run_idx_q + RUN_WIDTH'(1);
                state_q   <= S_FLUSH;
              end else begin
                done_flag_q <= 1'b1;
                state_q     <= S_IDLE;
              end
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign seq_io.dut_reset  = dut_reset_q;
  assign seq_io.dut_enable = dut_enable_q;
  assign seq_io.ram_we     = ram_we_q;
  assign seq_io.ram_addr   = ram_addr_q;
  assign seq_io.xfer_req   = xfer_req_q;
  assign seq_io.busy       = busy_q;
  assign seq_io.done       = done_q;
  assign seq_io.run_index  = run_index_q;

endmodule

// File: tb/tb_capture_run_sequencer.sv
// Randomized bench for capture_run_sequencer: two builds (PIPE_LATENCY 3 and 0)
// share one stimulus stream and are compared every edge against a run-schedule model.
module tb_capture_run_sequencer;

  localparam int AW = 4;
  localparam int RW = 8;
  localparam int D  = 16;
  localparam int F  = 2;

  logic clk;
  logic rst;

  capture_run_sequencer_if #(.ADDR_WIDTH(AW), .RUN_WIDTH(RW)) if0 ();
  capture_run_sequencer_if #(.ADDR_WIDTH(AW), .RUN_WIDTH(RW)) if1 ();

  capture_run_sequencer #(
    .ADDR_WIDTH(AW), .RAM_DEPTH(D), .PIPE_LATENCY(3), .FLUSH_CYCLES(F), .RUN_WIDTH(RW)
  ) dut0 (
    .variable_clk_2(clk),
    .reset(rst),
    .seq_io(if0)
  );

  capture_run_sequencer #(
    .ADDR_WIDTH(AW), .RAM_DEPTH(D), .PIPE_LATENCY(0), .FLUSH_CYCLES(F), .RUN_WIDTH(RW)
  ) dut1 (
    .variable_clk_2(clk),
    .reset(rst),
    .seq_io(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int edge_n;
  int wr_cnt;
  int flush_cnt;
  logic prev_dut_reset;

  // Model: a batch is "active" from its start edge; each run is timed from the
  // edge at which its flush began (m_t0), everything else is plain arithmetic.
  bit m_act  [2];
  bit m_done [2];
  int m_t0   [2];
  int m_runs [2];
  int m_idx  [2];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s edge=%0d got=%h expected=%h", tag, edge_n, got, exp);
    end
  endtask

  function automatic int pipe_of(input int i);
    return (i == 0) ? 3 : 0;
  endfunction

  // packed order: dut_reset, dut_enable, ram_we, ram_addr, xfer_req, busy, done, run_index
  function automatic logic [17:0] model_out(input int i, input int e);
    int k;
    int p;
    logic r, en, we, xr;
    logic [AW-1:0] a;
    r = 1'b0; en = 1'b0; we = 1'b0; xr = 1'b0; a = '0;
    p = pipe_of(i);
    if (m_act[i]) begin
      k = (e - 1) - m_t0[i];
      if (k < F) r = 1'b1;
      else if (k < F + p) en = 1'b1;
      else if (k < F + p + D) begin
        en = 1'b1; we = 1'b1; a = AW'(k - F - p);
      end else begin
        xr = 1'b1; a = AW'(D - 1);
      end
    end
    return {r, en, we, a, xr, m_act[i], m_done[i], RW'(m_idx[i])};
  endfunction

  task automatic model_update(input int i, input int e, input logic st, input logic [RW-1:0] nr,
                              input logic ab, input logic xd, input logic rs);
    int k;
    k = (e - 1) - m_t0[i];
    if (rs) begin
      m_act[i] = 1'b0; m_done[i] = 1'b0; m_idx[i] = 0;
    end else if (!m_act[i]) begin
      if (st) begin
        m_act[i] = 1'b1; m_t0[i] = e; m_idx[i] = 0; m_done[i] = 1'b0;
        m_runs[i] = (nr == 0) ? 1 : int'(nr);
      end
    end else if (ab) begin
      m_act[i] = 1'b0;
    end else if (k >= F + pipe_of(i) + D && xd) begin
      if (m_idx[i] + 1 < m_runs[i]) begin
        m_idx[i] = m_idx[i] + 1; m_t0[i] = e;
      end else begin
        m_act[i] = 1'b0; m_done[i] = 1'b1;
      end
    end
  endtask

  function automatic logic [17:0] pack0();
    return {if0.dut_reset, if0.dut_enable, if0.ram_we, if0.ram_addr, if0.xfer_req,
            if0.busy, if0.done, if0.run_index};
  endfunction

  function automatic logic [17:0] pack1();
    return {if1.dut_reset, if1.dut_enable, if1.ram_we, if1.ram_addr, if1.xfer_req,
            if1.busy, if1.done, if1.run_index};
  endfunction

  // One clock edge with the given inputs, then compare both builds 1 time unit later.
  task automatic step(input logic st, input logic [RW-1:0] nr, input logic ab,
                      input logic xd, input logic rs);
    logic [17:0] exp_v [2];
    if0.start = st; if0.num_runs = nr; if0.abort = ab; if0.xfer_done = xd;
    if1.start = st; if1.num_runs = nr; if1.abort = ab; if1.xfer_done = xd;
    rst = rs;
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      exp_v[i] = rs ? 18'd0 : model_out(i, edge_n);
      model_update(i, edge_n, st, nr, ab, xd, rs);
    end
    #1;
    check_value("outs_pl3", 32'(pack0()), 32'(exp_v[0]));
    check_value("outs_pl0", 32'(pack1()), 32'(exp_v[1]));
    if (if0.ram_we) wr_cnt++;
    if (if0.dut_reset && !prev_dut_reset) flush_cnt++;
    prev_dut_reset = if0.dut_reset;
  endtask

  // Transfer unit answering one cycle after each xfer_req of the PL=3 build.
  task automatic run_with_echo(input int cycles, input logic st, input logic [RW-1:0] nr,
                               input bit stray);
    logic xd;
    for (int c = 0; c < cycles; c++) begin
      xd = if0.xfer_req;
      if (stray && if0.ram_we && if0.ram_addr < AW'(13) && ($urandom_range(0, 3) == 0)) xd = 1'b1;
      step(st, nr, 1'b0, xd, 1'b0);
    end
  endtask

  initial begin
    bit hit;
    n_vec = 0; n_err = 0; edge_n = 0; wr_cnt = 0; flush_cnt = 0; prev_dut_reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_done[i] = 1'b0; m_t0[i] = 0; m_runs[i] = 1; m_idx[i] = 0;
    end

    for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // single run; transfer finishes at relative edge 30
    step(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 34; c++) step(1'b0, '0, 1'b0, (c == 30), 1'b0);

    // three runs with echoed transfer and stray xfer_done during capture
    wr_cnt = 0; flush_cnt = 0;
    step(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
    run_with_echo(100, 1'b0, '0, 1'b1);
    check_value("writes_3runs", 32'(wr_cnt), 32'd48);
    check_value("flushes_3runs", 32'(flush_cnt), 32'd3);

    // num_runs = 0 behaves as one run
    step(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    run_with_echo(35, 1'b0, '0, 1'b0);

    // abort during capture, then a clean restart
    step(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      if (if0.ram_we && if0.ram_addr == AW'(9)) hit = 1'b1;
      else step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    check_value("abort_reach", 32'(hit), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    run_with_echo(35, 1'b0, '0, 1'b0);

    // reset together with xfer_done while in XFER
    step(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      if (if0.xfer_req) hit = 1'b1;
      else step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    check_value("xfer_reach", 32'(hit), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    wr_cnt = 0;
    for (int c = 0; c < 10; c++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_value("writes_after_rst", 32'(wr_cnt), 32'd0);

    // start held high: re-triggers right after each done
    run_with_echo(90, 1'b1, 8'd1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // random traffic
    for (int c = 0; c < 800; c++) begin
      step(($urandom_range(0, 7) == 0), RW'($urandom_range(0, 3)), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 255) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
